spi_flash_page_writer: RTL and testbench

Single-bit SPI write engine for the on-board configuration flash; the write-side counterpart of the DSPI flash reader. It performs either a 4 KB sector erase or a page program of 1..256 bytes streamed in through a byte handshake. For each operation it issues the WREN preamble, then the erase or program frame, then polls status until the flash is no longer busy. It shares the flash pins with the reader through a top-level mux, and the flash SCK is the free-running system clock, gated only by cs.

---
 rtl/spi_flash_pkg.sv | 29 ++
 rtl/spi_shift_out.sv | 40 ++++
 rtl/spi_flash_page_writer.sv | 180 ++++++++++++++++++
 tb/tb_spi_flash_page_writer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, operation and state encodings for the SPI flash write engine.
package spi_flash_pkg;

    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_SE   = 8'h20;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    typedef enum logic {
        OP_PROGRAM = 1'b0,
        OP_ERASE   = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WREN,
        S_GAP,
        S_FRAME,
        S_DATA,
        S_POLL,
        S_DONE
    } state_e;

    // An 8-bit command left-aligned in the 32-bit shifter; idle bits read as 1.
    function automatic logic [31:0] cmd_word(input logic [7:0] opcode);
        return {opcode, 24'hFF_FFFF};
    endfunction

endpackage

// File: rtl/spi_shift_out.sv
// MSB-first MOSI shifter: one bit per clk, loadable with 1..32 bits, idles at 1.
module spi_shift_out (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [5:0]  nbits,
    output logic        spi_di,
    output logic        last,
    output logic        near_last
);
    logic [31:0] shift_reg;
    logic [4:0]  cnt_reg;
    logic        active_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shift_reg  <= '1;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
        end else if (load) begin
            shift_reg  <= data;
            cnt_reg    <= 5'(nbits - 6'd1);
            active_reg <= 1'b1;
        end else if (active_reg) begin
            if (cnt_reg == 5'd0) begin
                shift_reg  <= '1;
                active_reg <= 1'b0;
            end else begin
                shift_reg <= {shift_reg[30:0], 1'b1};
                cnt_reg   <= cnt_reg - 5'd1;
            end
        end
    end

    assign spi_di    = shift_reg[31];
    assign last      = active_reg && (cnt_reg == 5'd0);
    assign near_last = active_reg && (cnt_reg == 5'd1);

endmodule

// File: rtl/spi_flash_page_writer.sv
// SPI flash write engine: WREN, then sector erase or page program, then RDSR polling.
module spi_flash_page_writer
    import spi_flash_pkg::*;
#(
    parameter int GAP_CYCLES = 4,
    parameter int POLL_MAX   = 27_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        op,
    input  logic [23:0] addr,
    input  logic [8:0]  len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cs,
    output logic        spi_di,
    input  logic        spi_do
);
    state_e      state;
    op_e         op_reg;
    logic [23:0] addr_reg;
    logic [8:0]  bytes_left_reg;
    logic [3:0]  gap_cnt_reg;
    logic [31:0] poll_cnt_reg;
    logic        to_poll_reg;
    logic        reading_reg;

    logic        load;
    logic [31:0] load_word;
    logic [5:0]  load_bits;
    logic        last;
    logic        near_last;
    logic        empty_program;
    logic        byte_load;
    logic        poll_timeout;

    assign empty_program = (op_e'(op) == OP_PROGRAM) && (len == 9'd0);
    assign byte_load     = ((state == S_FRAME) || (state == S_DATA)) && last && wr_ready && wr_valid;
    assign poll_timeout  = (poll_cnt_reg == 32'(POLL_MAX - 1));

    // Shifter loads happen on the same edge the FSM decides, so they are decoded here.
    always_comb begin
        load      = 1'b0;
        load_word = '1;
        load_bits = 6'd8;
        case (state)
            S_IDLE: if (start && !empty_program) begin
                load      = 1'b1;
                load_word = cmd_word(CMD_WREN);
            end
            S_GAP: if (gap_cnt_reg == 4'd0) begin
                load = 1'b1;
                if (to_poll_reg) begin
                    load_word = cmd_word(CMD_RDSR);
                end else begin
                    load_word = {(op_reg == OP_ERASE) ? CMD_SE : CMD_PP, addr_reg};
                    load_bits = 6'd32;
                end
            end
            S_FRAME, S_DATA: if (byte_load) begin
                load      = 1'b1;
                load_word = {wr_data, 24'hFF_FFFF};
            end
            S_POLL: if (last && !poll_timeout && (!reading_reg || spi_do)) begin
                load = 1'b1;
            end
            default: ;
        endcase
    end

    spi_shift_out u_shift (
        .clk       (clk),
        .rstn      (rstn),
        .load      (load),
        .data      (load_word),
        .nbits     (load_bits),
        .spi_di    (spi_di),
        .last      (last),
        .near_last (near_last)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= S_IDLE;
            op_reg         <= OP_PROGRAM;
            addr_reg       <= '0;
            bytes_left_reg <= '0;
            gap_cnt_reg    <= '0;
            poll_cnt_reg   <= '0;
            to_poll_reg    <= 1'b0;
            reading_reg    <= 1'b0;
            cs             <= 1'b1;
            wr_ready       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            done     <= 1'b0;
            wr_ready <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    busy <= 1'b1;
                    if (empty_program) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        op_reg         <= op_e'(op);
                        addr_reg       <= addr;
                        bytes_left_reg <= len;
                        err            <= 1'b0;
                        cs             <= 1'b0;
                        state          <= S_WREN;
                    end
                end
                S_WREN: if (last) begin
                    cs          <= 1'b1;
                    gap_cnt_reg <= 4'(GAP_CYCLES - 1);
                    to_poll_reg <= 1'b0;
                    state       <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt_reg == 4'd0) begin
                        cs           <= 1'b0;
                        poll_cnt_reg <= '0;
                        reading_reg  <= 1'b0;
                        state        <= to_poll_reg ? S_POLL : S_FRAME;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 4'd1;
                    end
                end
                S_FRAME, S_DATA: begin
                    if (near_last) begin
                        wr_ready <= (state == S_FRAME) ? (op_reg == OP_PROGRAM) : (bytes_left_reg != 9'd0);
                    end
                    if (last) begin
                        if (byte_load) begin
                            bytes_left_reg <= bytes_left_reg - 9'd1;
                            state          <= S_DATA;
                        end else begin
                            // A missed byte ends the frame on a byte boundary; still poll.
                            if (wr_ready) err <= 1'b1;
                            cs          <= 1'b1;
                            gap_cnt_reg <= 4'(GAP_CYCLES - 1);
                            to_poll_reg <= 1'b1;
                            state       <= S_GAP;
                        end
                    end
                end
                S_POLL: begin
                    poll_cnt_reg <= poll_cnt_reg + 32'd1;
                    if (poll_timeout) begin
                        cs    <= 1'b1;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (last) begin
                        if (!reading_reg) begin
                            reading_reg <= 1'b1;
                        end else if (!spi_do) begin
                            cs    <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_page_writer.sv
// Directed bench: records every cs-low frame on MOSI and answers RDSR with a WIP model.
module tb_spi_flash_page_writer;
    logic        clk      = 1'b0;
    logic        rstn     = 1'b0;
    logic        start    = 1'b0;
    logic        op       = 1'b0;
    logic [23:0] addr     = '0;
    logic [8:0]  len      = '0;
    logic [7:0]  wr_data  = '0;
    logic        wr_valid = 1'b0;
    logic        spi_do   = 1'b0;
    logic        wr_ready, busy, done, err, cs, spi_di;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx [0:7];
    int          drop_idx  = -1;
    int          wip_bytes = 0;

    logic [63:0] fbits [0:127];
    int          flen  [0:127];
    int          fgap  [0:127];
    int          nfr = 0;
    bit          in_frame = 1'b0;
    logic [63:0] cur_bits = '0;
    int          cur_len = 0;
    int          high_run = 0;
    int          gap_before = 0;
    logic [7:0]  first_byte = '0;

    spi_flash_page_writer #(
        .GAP_CYCLES (4),
        .POLL_MAX   (100)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .op       (op),
        .addr     (addr),
        .len      (len),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cs       (cs),
        .spi_di   (spi_di),
        .spi_do   (spi_do)
    );

    always #5 clk = ~clk;

    // Flash model: capture MOSI mid-bit, drive each status byte's WIP bit for the next rising edge.
    always @(negedge clk) begin
        if (!cs) begin
            if (!in_frame) begin
                in_frame   = 1'b1;
                cur_bits   = '0;
                cur_len    = 0;
                first_byte = 8'h00;
                gap_before = high_run;
            end
            cur_bits = {cur_bits[62:0], spi_di};
            if (cur_len == 7) first_byte = cur_bits[7:0];
            if (cur_len >= 8 && first_byte == 8'h05)
                spi_do = (((cur_len - 8) % 8) == 7) && (((cur_len - 8) / 8) < wip_bytes);
            else
                spi_do = 1'b0;
            cur_len++;
        end else begin
            spi_do = 1'b0;
            if (in_frame) begin
                if (nfr < 128) begin
                    fbits[nfr] = cur_bits;
                    flen[nfr]  = cur_len;
                    fgap[nfr]  = gap_before;
                end
                nfr++;
                in_frame = 1'b0;
                high_run = 0;
            end
            high_run++;
        end
    end

    task automatic run_op(input logic op_i, input logic [23:0] addr_i, input logic [8:0] len_i,
                          input int inject_at, output int dones, output int readys, output logic err_start);
        int  byte_idx = 0;
        bit  acc = 1'b0;
        int  post = 0;
        dones = 0;
        readys = 0;
        op = op_i; addr = addr_i; len = len_i; start = 1'b1;
        wr_data = tx[0]; wr_valid = (drop_idx != 0);
        @(negedge clk);
        start = 1'b0;
        err_start = err;
        for (int cyc = 0; cyc < 2000 && post < 10; cyc++) begin
            if (done) dones++;
            if (wr_ready) readys++;
            if (dones > 0) post++;
            if (acc) byte_idx++;
            acc = wr_ready && wr_valid;
            if (byte_idx < 8) wr_data = tx[byte_idx];
            wr_valid = (byte_idx != drop_idx);
            start = (cyc == inject_at);
            @(negedge clk);
        end
        start = 1'b0;
        $display("txn op=%0d addr=%06h len=%0d dones=%0d readys=%0d err=%0b", op_i, addr_i, len_i, dones, readys, err);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cs !== 1'b1)       begin errors++; $display("FAIL reset_cs got %b want 1", cs); end
        checks++; if (spi_di !== 1'b1)   begin errors++; $display("FAIL reset_spi_di got %b want 1", spi_di); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL reset_err got %b want 0", err); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        $display("txn reset released");
    endtask

    task automatic test_program();
        int b, d, r;
        logic e0;
        tx[0] = 8'hA5; tx[1] = 8'h3C; tx[2] = 8'h00; tx[3] = 8'hFF;
        drop_idx = -1; wip_bytes = 3;
        b = nfr;
        run_op(1'b0, 24'h400010, 9'd4, -1, d, r, e0);
        checks++; if (nfr - b != 3)      begin errors++; $display("FAIL pp_frames got %0d want 3", nfr - b); end
        checks++; if (flen[b] != 8)      begin errors++; $display("FAIL pp_wren_len got %0d want 8", flen[b]); end
        checks++; if (fbits[b] !== 64'h06) begin errors++; $display("FAIL pp_wren got %h want 06", fbits[b]); end
        checks++; if (fgap[b+1] != 4)    begin errors++; $display("FAIL pp_gap1 got %0d want 4", fgap[b+1]); end
        checks++; if (flen[b+1] != 64)   begin errors++; $display("FAIL pp_frame_len got %0d want 64", flen[b+1]); end
        checks++; if (fbits[b+1] !== 64'h0240_0010_A53C_00FF) begin errors++; $display("FAIL pp_frame got %h want 02400010a53c00ff", fbits[b+1]); end
        checks++; if (r != 4)            begin errors++; $display("FAIL pp_ready_pulses got %0d want 4", r); end
        checks++; if (fgap[b+2] != 4)    begin errors++; $display("FAIL pp_gap2 got %0d want 4", fgap[b+2]); end
        checks++; if (flen[b+2] != 40)   begin errors++; $display("FAIL pp_poll_len got %0d want 40", flen[b+2]); end
        checks++; if (fbits[b+2] !== 64'h05_FFFF_FFFF) begin errors++; $display("FAIL pp_poll got %h want 05ffffffff", fbits[b+2]); end
        checks++; if (d != 1)            begin errors++; $display("FAIL pp_done got %0d want 1", d); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL pp_err got %b want 0", err); end
    endtask

    task automatic test_erase();
        int b, d, r;
        logic e0;
        drop_idx = -1; wip_bytes = 2;
        b = nfr;
        run_op(1'b1, 24'h401000, 9'd0, -1, d, r, e0);
        checks++; if (nfr - b != 3)      begin errors++; $display("FAIL se_frames got %0d want 3", nfr - b); end
        checks++; if (fbits[b] !== 64'h06) begin errors++; $display("FAIL se_wren got %h want 06", fbits[b]); end
        checks++; if (flen[b+1] != 32)   begin errors++; $display("FAIL se_frame_len got %0d want 32", flen[b+1]); end
        checks++; if (fbits[b+1] !== 64'h2040_1000) begin errors++; $display("FAIL se_frame got %h want 20401000", fbits[b+1]); end
        checks++; if (fgap[b+1] != 4)    begin errors++; $display("FAIL se_gap1 got %0d want 4", fgap[b+1]); end
        checks++; if (r != 0)            begin errors++; $display("FAIL se_ready_pulses got %0d want 0", r); end
        checks++; if (flen[b+2] != 32)   begin errors++; $display("FAIL se_poll_len got %0d want 32", flen[b+2]); end
        checks++; if (d != 1)            begin errors++; $display("FAIL se_done got %0d want 1", d); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL se_err got %b want 0", err); end
    endtask

    task automatic test_underrun();
        int b, d, r;
        logic e0;
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
        drop_idx = 1; wip_bytes = 0;
        b = nfr;
        run_op(1'b0, 24'h000100, 9'd3, -1, d, r, e0);
        drop_idx = -1;
        checks++; if (nfr - b != 3)      begin errors++; $display("FAIL ur_frames got %0d want 3", nfr - b); end
        checks++; if (flen[b+1] != 40)   begin errors++; $display("FAIL ur_frame_len got %0d want 40", flen[b+1]); end
        checks++; if (fbits[b+1] !== 64'h02_0001_0011) begin errors++; $display("FAIL ur_frame got %h want 0200010011", fbits[b+1]); end
        checks++; if (r != 2)            begin errors++; $display("FAIL ur_ready_pulses got %0d want 2", r); end
        checks++; if (flen[b+2] != 16)   begin errors++; $display("FAIL ur_poll_len got %0d want 16", flen[b+2]); end
        checks++; if (d != 1)            begin errors++; $display("FAIL ur_done got %0d want 1", d); end
        checks++; if (err !== 1'b1)      begin errors++; $display("FAIL ur_err got %b want 1", err); end
    endtask

    task automatic test_len_zero();
        int b;
        b = nfr;
        op = 1'b0; len = 9'd0; addr = 24'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL z_busy1 got %b want 1", busy); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL z_done1 got %b want 1", done); end
        checks++; if (cs !== 1'b1)   begin errors++; $display("FAIL z_cs1 got %b want 1", cs); end
        checks++; if (err !== 1'b1)  begin errors++; $display("FAIL z_err_kept got %b want 1", err); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL z_busy2 got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL z_done2 got %b want 0", done); end
        repeat (5) @(negedge clk);
        checks++; if (nfr - b != 0)  begin errors++; $display("FAIL z_frames got %0d want 0", nfr - b); end
        $display("txn op=0 len=0 empty program");
    endtask

    task automatic test_timeout();
        int b, d, r;
        logic e0;
        drop_idx = -1; wip_bytes = 100000;
        b = nfr;
        run_op(1'b1, 24'h000000, 9'd0, -1, d, r, e0);
        checks++; if (nfr - b != 3)    begin errors++; $display("FAIL to_frames got %0d want 3", nfr - b); end
        checks++; if (flen[b+2] != 100) begin errors++; $display("FAIL to_poll_len got %0d want 100", flen[b+2]); end
        checks++; if (d != 1)          begin errors++; $display("FAIL to_done got %0d want 1", d); end
        checks++; if (err !== 1'b1)    begin errors++; $display("FAIL to_err got %b want 1", err); end
    endtask

    task automatic test_back_to_back();
        int b, d, r;
        logic e0;
        drop_idx = -1; wip_bytes = 1;
        b = nfr;
        run_op(1'b1, 24'h002000, 9'd0, 20, d, r, e0);
        checks++; if (e0 !== 1'b0)      begin errors++; $display("FAIL bb_err_cleared got %b want 0", e0); end
        checks++; if (nfr - b != 3)     begin errors++; $display("FAIL bb_frames got %0d want 3", nfr - b); end
        checks++; if (fbits[b+1] !== 64'h2000_2000) begin errors++; $display("FAIL bb_frame got %h want 20002000", fbits[b+1]); end
        checks++; if (flen[b+2] != 24)  begin errors++; $display("FAIL bb_poll_len got %0d want 24", flen[b+2]); end
        checks++; if (d != 1)           begin errors++; $display("FAIL bb_done got %0d want 1", d); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL bb_err got %b want 0", err); end
    endtask

    task automatic test_reset_mid_data();
        int b, r, after;
        r = 0;
        tx[0] = 8'h5A; drop_idx = -1; wip_bytes = 0;
        b = nfr;
        op = 1'b0; addr = 24'h123456; len = 9'd4; start = 1'b1; wr_data = tx[0]; wr_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (wr_ready) r++;
            if (r == 2) break;
            @(negedge clk);
        end
        checks++; if (r != 2) begin errors++; $display("FAIL rd_reach_data got %0d want 2", r); end
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (cs !== 1'b1)       begin errors++; $display("FAIL rd_cs got %b want 1", cs); end
        checks++; if (spi_di !== 1'b1)   begin errors++; $display("FAIL rd_spi_di got %b want 1", spi_di); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rd_wr_ready got %b want 0", wr_ready); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rd_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rd_done got %b want 0", done); end
        checks++; if (err !== 1'b0)      begin errors++; $display("FAIL rd_err got %b want 0", err); end
        rstn = 1'b1; wr_valid = 1'b0;
        @(negedge clk);
        checks++; if (nfr - b != 2)      begin errors++; $display("FAIL rd_frames got %0d want 2", nfr - b); end
        checks++; if (flen[b+1] != 40)   begin errors++; $display("FAIL rd_cut_len got %0d want 40", flen[b+1]); end
        after = nfr;
        repeat (20) @(negedge clk);
        checks++; if (nfr != after)      begin errors++; $display("FAIL rd_quiet got %0d want %0d", nfr, after); end
        $display("txn program interrupted by reset");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) tx[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_program();
        test_erase();
        test_underrun();
        test_len_zero();
        test_timeout();
        test_back_to_back();
        test_reset_mid_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
